// File: rtl/msk_rnd_source.sv
// Fresh-randomness source for masked gadgets: RW seeded 32-bit Galois LFSR lanes, one bit per lane per transfer.
// Optional periodic reseed request is compiled in with `define MSKRND_RESEED_EN.
module msk_rnd_source #(
  parameter int d             = 2,
  parameter int RW            = d * (d - 1),
  parameter int RESEED_PERIOD = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   seed_data,
  input  logic          seed_valid,
  output logic          seed_ready,
  output logic [RW-1:0] rnd,
  output logic          rnd_valid,
  input  logic          rnd_ready,
  output logic          need_seed
);

  localparam int          IW   = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [31:0] POLY = 32'h80200003;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    LOADING  = 2'd1,
    RUN      = 2'd2
  } state_t;

  if (d < 2) begin : g_bad_shares
    $error("msk_rnd_source: d must be at least 2");
  end
  if (RW < 1) begin : g_bad_width
    $error("msk_rnd_source: RW must be at least 1");
  end
  if (RESEED_PERIOD < 1 || RESEED_PERIOD > (1 << 20)) begin : g_bad_period
    $error("msk_rnd_source: RESEED_PERIOD outside 1..2^20");
  end

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   lane [RW];
  logic [IW-1:0] idx;
  logic          seed_hs;
  logic          rnd_hs;
  logic          last_lane;
  logic          reseed_due;
  logic [31:0]   seed_word;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  assign seed_hs   = seed_valid & seed_ready;
  assign rnd_hs    = rnd_valid & rnd_ready;
  assign last_lane = (idx == IW'(RW - 1));
  // An all-zero seed would lock a lane at zero forever.
  assign seed_word = (seed_data == 32'h0) ? 32'h00000001 : seed_data;

`ifdef MSKRND_RESEED_EN
  localparam int CW = $clog2(RESEED_PERIOD + 1);

  logic [CW-1:0] xfer_cnt;

  assign reseed_due = rnd_hs && (xfer_cnt == CW'(RESEED_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (rnd_hs) begin
      xfer_cnt <= reseed_due ? '0 : xfer_cnt + 1'b1;
    end
  end
`else
  assign reseed_due = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNSEEDED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNSEEDED, LOADING: begin
        // With a single lane the first seed word is also the last one.
        if (seed_hs) begin
          state_nxt = last_lane ? RUN : LOADING;
        end
      end
      RUN: begin
        if (reseed_due) begin
          state_nxt = UNSEEDED;
        end
      end
      default: state_nxt = UNSEEDED;
    endcase
  end

  always_comb begin
    seed_ready = 1'b0;
    rnd_valid  = 1'b0;
    need_seed  = 1'b0;
    case (state)
      UNSEEDED, LOADING: begin
        seed_ready = 1'b1;
        need_seed  = 1'b1;
      end
      RUN: begin
        rnd_valid = 1'b1;
      end
      default: begin
        seed_ready = 1'b0;
        rnd_valid  = 1'b0;
        need_seed  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (seed_hs) begin
      idx <= last_lane ? '0 : idx + 1'b1;
    end else if (reseed_due) begin
      idx <= '0;
    end
  end

  // Lanes survive a reseed request; they are only replaced word by word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RW; k++) begin
        lane[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < RW; k++) begin
        if (seed_hs && (idx == IW'(k))) begin
          lane[k] <= seed_word;
        end else if (rnd_hs) begin
          lane[k] <= lfsr_step(lane[k]);
        end
      end
    end
  end

  always_comb begin
    rnd = '0;
    for (int k = 0; k < RW; k++) begin
      rnd[k] = lane[k][0];
    end
  end

endmodule

// File: tb/tb_msk_rnd_source.sv
// Directed bench for msk_rnd_source at d=2 (two lanes); drives and samples on the falling clock edge.
module tb_msk_rnd_source;

`ifdef MSKRND_RESEED_EN
  localparam int RP = 4;
`else
  localparam int RP = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seed_data;
  logic        seed_valid;
  logic        seed_ready;
  logic [1:0]  rnd;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        need_seed;

  int total = 0;
  int bad   = 0;

  logic [31:0] m0;
  logic [31:0] m1;

  msk_rnd_source #(.d(2), .RESEED_PERIOD(RP)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_data  (seed_data),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .need_seed  (need_seed)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] t;
    t = {1'b0, s[31:1]};
    if (s[0]) t = t ^ 32'h80200003;
    return t;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w);
    return (w == 32'h0) ? 32'h1 : w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".seed_ready"}, {31'h0, seed_ready}, 32'h1);
    check({tag, ".rnd_valid"},  {31'h0, rnd_valid},  32'h0);
    check({tag, ".rnd"},        {30'h0, rnd},        32'h0);
    check({tag, ".need_seed"},  {31'h0, need_seed},  32'h1);
  endtask

  // Caller leaves the block in UNSEEDED at a falling edge with rst low.
  task automatic load2(input logic [31:0] a, input logic [31:0] b);
    seed_valid = 1'b1;
    seed_data  = a;
    @(negedge clk);
    seed_data  = b;
    @(negedge clk);
    seed_valid = 1'b0;
    m0 = ref_load(a);
    m1 = ref_load(b);
  endtask

  task automatic run_steps(input int n, input string tag);
    rnd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m0 = ref_step(m0);
      m1 = ref_step(m1);
      check(tag, {30'h0, rnd}, {30'h0, m1[0], m0[0]});
    end
    rnd_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    seed_data  = 32'h0;
    seed_valid = 1'b0;
    rnd_ready  = 1'b0;
    m0 = 32'h0;
    m1 = 32'h0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // first seed word is presented as reset is released
    rst        = 1'b0;
    seed_valid = 1'b1;
    seed_data  = 32'h00000001;
    @(negedge clk);
    check("loading.need_seed",  {31'h0, need_seed},  32'h1);
    check("loading.rnd_valid",  {31'h0, rnd_valid},  32'h0);
    check("loading.seed_ready", {31'h0, seed_ready}, 32'h1);
    seed_data = 32'h00000002;
    @(negedge clk);
    seed_valid = 1'b0;
    m0 = 32'h1;
    m1 = 32'h2;
    check("run.rnd_valid",  {31'h0, rnd_valid},  32'h1);
    check("run.seed_ready", {31'h0, seed_ready}, 32'h0);
    check("run.need_seed",  {31'h0, need_seed},  32'h0);
    check("run.first_rnd",  {30'h0, rnd},        32'h1);
    run_steps(1, "step1.model");
    check("step1.rnd", {30'h0, rnd}, 32'h3);
    check("step1.lane0_model", m0, 32'h80200003);

`ifndef MSKRND_RESEED_EN
    rnd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall.rnd",       {30'h0, rnd},       {30'h0, m1[0], m0[0]});
      check("stall.rnd_valid", {31'h0, rnd_valid}, 32'h1);
    end
    run_steps(5, "after_stall");

    seed_valid = 1'b1;
    seed_data  = 32'hDEADBEEF;
    @(negedge clk);
    check("run_seed.seed_ready", {31'h0, seed_ready}, 32'h0);
    run_steps(6, "run_seed.rnd");
    seed_valid = 1'b0;

    run_steps(20, "long_run.rnd");
    check("long_run.rnd_valid", {31'h0, rnd_valid}, 32'h1);
    check("long_run.need_seed", {31'h0, need_seed}, 32'h0);
`else
    do_reset();
    load2(32'h00000001, 32'h00000002);
    run_steps(3, "reseed.pre");
    check("reseed.still_valid", {31'h0, rnd_valid}, 32'h1);
    run_steps(1, "reseed.fourth");
    check("reseed.rnd_valid",  {31'h0, rnd_valid},  32'h0);
    check("reseed.need_seed",  {31'h0, need_seed},  32'h1);
    check("reseed.seed_ready", {31'h0, seed_ready}, 32'h1);
    load2(32'h00000005, 32'h00000006);
    check("reseed.resume_valid", {31'h0, rnd_valid}, 32'h1);
    check("reseed.resume_rnd",   {30'h0, rnd},       32'h1);
    run_steps(2, "reseed.resume_steps");
`endif

    // reset in the middle of seed loading
    do_reset();
    seed_valid = 1'b1;
    seed_data  = 32'h00001234;
    @(negedge clk);
    seed_valid = 1'b0;
    check("midload.need_seed", {31'h0, need_seed}, 32'h1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midload_rst");
    @(negedge clk);
    rst = 1'b0;
    load2(32'h00000001, 32'h00000002);
    check("reload.rnd_valid", {31'h0, rnd_valid}, 32'h1);
    check("reload.rnd",       {30'h0, rnd},       32'h1);
    run_steps(1, "reload.model");
    check("reload.step_rnd", {30'h0, rnd}, 32'h3);

    // zero seeds are replaced by 1
    do_reset();
    load2(32'h0, 32'h0);
    check("zero.rnd", {30'h0, rnd}, 32'h3);
    run_steps(1, "zero.step1");
    check("zero.step1_rnd", {30'h0, rnd}, 32'h3);
    run_steps(1, "zero.step2");
    check("zero.step2_rnd", {30'h0, rnd}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msk_rnd_source.md
MSK_RND_SOURCE -- requirements
Module: msk_rnd_source

Interface
REQ-001 SHALL have parameter d, default 2, meaning the number of shares of the consuming gadget.
REQ-002 SHALL have parameter RW, default d*(d-1), meaning random bits delivered per transfer (two triangular matrices of d(d-1)/2 bits each).
REQ-003 SHALL have parameter RESEED_PERIOD, default 1024, meaning accepted transfers between reseeds (used only with MSKRND_RESEED_EN; legal range 1..2^20).
REQ-004 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: seed_data  input  32  seed word for one LFSR lane.
REQ-007 SHALL have port: seed_valid  input  1  seed_data is valid.
REQ-008 SHALL have port: seed_ready  output  1  block accepts a seed word this cycle.
REQ-009 SHALL have port: rnd  output  RW  fresh random bits; rnd[k] is lane k.
REQ-010 SHALL have port: rnd_valid  output  1  rnd is valid.
REQ-011 SHALL have port: rnd_ready  input  1  consumer takes rnd this cycle.
REQ-012 SHALL have port: need_seed  output  1  high in UNSEEDED and LOADING.

Function
REQ-013 SHALL hold RW independent 32-bit Galois LFSR lanes, polynomial x^32+x^22+x^2+x+1; step: s = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
REQ-014 SHALL drive rnd[k] = bit 0 of lane k, a direct function of registered state (no input-to-output combinational path).
REQ-015 SHALL implement states UNSEEDED, LOADING, RUN.
REQ-016 UNSEEDED: seed_ready=1, rnd_valid=0; seed handshake loads lane 0 and moves to LOADING (or to RUN directly if RW=1).
REQ-017 LOADING: seed_ready=1, rnd_valid=0; each seed handshake loads lane idx, idx increments; handshake on lane RW-1 moves to RUN next cycle.
REQ-018 A seed word equal to 0 SHALL be replaced by 32'h00000001 when loaded.
REQ-019 RUN: seed_ready=0, rnd_valid=1; seed_valid ignored.
REQ-020 On rnd_valid & rnd_ready all lanes SHALL step once; new rnd visible the next cycle (one transfer per cycle sustained).
REQ-021 With rnd_ready=0 in RUN, lane state and rnd SHALL hold stable.
REQ-022 First rnd after loading SHALL equal bit 0 of the loaded seeds (latency: 1 cycle from final seed handshake to rnd_valid=1).
REQ-023 Lane index counter SHALL be $clog2(RW) bits minimum and clear on entry to UNSEEDED.

Reset
REQ-024 Asserting rst at any time (including mid-LOADING or mid-RUN) SHALL immediately force: state UNSEEDED, all lanes 0, idx 0, transfer counter 0.
REQ-025 Output reset values: seed_ready=1, rnd_valid=0, rnd=0, need_seed=1.
REQ-026 First seed handshake SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro MSKRND_RESEED_EN defined: a transfer counter counts rnd handshakes in RUN; the handshake that makes it reach RESEED_PERIOD SHALL move the block to UNSEEDED next cycle (counter cleared, lanes retained until overwritten), so rnd_valid drops and need_seed rises.
REQ-028 Macro MSKRND_RESEED_EN undefined: no transfer counter is synthesized; RUN persists until rst; RESEED_PERIOD has no effect.

Verification
REQ-029 d=2 (RW=2): reset, seeds 32'h00000001 then 32'h00000002 -> one cycle later rnd_valid=1, rnd=2'b01; after one handshake rnd=2'b11 (lanes 32'h80200003, 32'h00000001).
REQ-030 Seeds 32'h0, 32'h0 -> first rnd=2'b11, lanes equal 32'h00000001 each; never an all-zero lane.
REQ-031 RUN with rnd_ready=0 for 10 cycles -> rnd and rnd_valid constant; then rnd_ready=1 for 5 cycles -> 5 distinct steps matching the software LFSR model.
REQ-032 MSKRND_RESEED_EN, RESEED_PERIOD=4 -> after exactly 4 handshakes rnd_valid=0, need_seed=1, seed_ready=1; fresh 2-word seed resumes RUN.
REQ-033 rst asserted after first seed word in LOADING -> outputs immediately at reset values; subsequent full seed sequence yields rnd identical to REQ-029.
REQ-034 seed_valid=1 held during RUN -> seed_ready=0, lane state unaffected, rnd sequence matches model.
